// File: rtl/jpeg_entropy_unstuffer_if.sv
`default_nettype none
// ============================================================================
// Module      : jpeg_entropy_unstuffer_if
// Description : Byte-source and bit-consumer signal bundle of the JPEG
//               entropy unstuffer.
//               slave  - the unstuffer itself
//               master - byte source plus Huffman decoder side
//               Byte side  : in_data, in_valid, in_ready
//               Bit side   : peek_bits, bit_count, consume_en, consume_len
//               Marker side: marker_valid, marker_code, marker_ack
//               Status     : underflow_err
// Revision    : 1.0 - initial release
// ============================================================================
interface jpeg_entropy_unstuffer_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] peek_bits;
    logic [5:0]  bit_count;
    logic        consume_en;
    logic [4:0]  consume_len;
    logic        marker_valid;
    logic [7:0]  marker_code;
    logic        marker_ack;
    logic        underflow_err;

    modport slave (
        input  in_data, in_valid, consume_en, consume_len, marker_ack,
        output in_ready, peek_bits, bit_count, marker_valid, marker_code,
               underflow_err
    );

    modport master (
        output in_data, in_valid, consume_en, consume_len, marker_ack,
        input  in_ready, peek_bits, bit_count, marker_valid, marker_code,
               underflow_err
    );
endinterface
`default_nettype wire

// File: rtl/jpeg_entropy_unstuffer.sv
`default_nettype none
// ============================================================================
// Module      : jpeg_entropy_unstuffer
// Description : Removes 0xFF00 byte stuffing and 0xFF fill bytes from the
//               entropy-coded stream, halts on markers (RSTn/EOI) and
//               presents an MSB-first 16-bit peek window to the Huffman
//               decoder, which consumes 1..16 bits per cycle.
// Ports       : clk   - clock, rising edge
//               rst_n - asynchronous active-low reset
//               bus   - jpeg_entropy_unstuffer_if.slave (byte input, peek
//                       window, consume request, marker handshake, error)
// Parameters  : BUF_W - bit-buffer depth in bits (multiple of 8, 24..63)
// Revision    : 1.0 - initial release
// ============================================================================
module jpeg_entropy_unstuffer #(
    parameter int BUF_W = 32
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    jpeg_entropy_unstuffer_if.slave   bus
);

    localparam logic [1:0] S_DATA   = 2'd0;
    localparam logic [1:0] S_FF     = 2'd1;
    localparam logic [1:0] S_MARKER = 2'd2;

    // Highest fill level at which a whole byte still fits.
    localparam logic [6:0]       c_FILL_LIMIT = 7'(BUF_W - 8);
    localparam logic [BUF_W-1:0] c_ALL_ONES   = {BUF_W{1'b1}};
    localparam logic [BUF_W-1:0] c_BYTE_MASK  = {{(BUF_W-8){1'b0}}, 8'hFF};

    // The buffer is kept MSB-aligned: the oldest bit sits at BUF_W-1 and
    // every position beyond bit_count holds a 1, so the peek window's
    // padding comes for free.
    logic [1:0]       r_state;
    logic [BUF_W-1:0] r_buf;
    logic [5:0]       r_bit_count;
    logic             r_marker_valid;
    logic [7:0]       r_marker_code;
    logic             r_underflow_err;

    logic [6:0]       w_cnt;
    logic [6:0]       w_len;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_underflow;
    logic             w_flush;
    logic [1:0]       w_state_next;
    logic             w_append;
    logic [7:0]       w_app_byte;
    logic             w_marker_hit;
    logic [BUF_W-1:0] w_buf_cons;
    logic [6:0]       w_cnt_cons;
    logic [6:0]       w_app_shift;
    logic [BUF_W-1:0] w_buf_next;
    logic [5:0]       w_cnt_next;

    assign w_cnt       = {1'b0, r_bit_count};
    assign w_len       = {2'b00, bus.consume_len};
    // Depends only on registered state so no path from in_valid/consume_en.
    assign w_in_ready  = (r_state != S_MARKER) && (w_cnt <= c_FILL_LIMIT);
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_underflow = bus.consume_en && (w_len > w_cnt);
    assign w_flush     = bus.marker_ack && (r_state == S_MARKER);

    // Byte classification
    always_comb begin
        w_state_next = r_state;
        w_append     = 1'b0;
        w_app_byte   = bus.in_data;
        w_marker_hit = 1'b0;
        case (r_state)
            S_DATA: begin
                if (w_accept) begin
                    if (bus.in_data == 8'hFF) w_state_next = S_FF;
                    else                      w_append     = 1'b1;
                end
            end
            S_FF: begin
                if (w_accept) begin
                    if (bus.in_data == 8'h00) begin
                        w_append     = 1'b1;
                        w_app_byte   = 8'hFF;
                        w_state_next = S_DATA;
                    end else if (bus.in_data != 8'hFF) begin
                        w_marker_hit = 1'b1;
                        w_state_next = S_MARKER;
                    end
                end
            end
            S_MARKER: begin
                if (w_flush) w_state_next = S_DATA;
            end
            default: w_state_next = S_DATA;
        endcase
    end

    // Buffer update: consume (or flush / underflow clear) first, then append
    // the new byte directly behind whatever survived.
    always_comb begin
        w_buf_cons = r_buf;
        w_cnt_cons = w_cnt;
        if (w_flush || w_underflow) begin
            w_buf_cons = c_ALL_ONES;
            w_cnt_cons = 7'd0;
        end else if (bus.consume_en) begin
            w_buf_cons = (r_buf << bus.consume_len) | ~(c_ALL_ONES << bus.consume_len);
            w_cnt_cons = w_cnt - w_len;
        end

        w_app_shift = c_FILL_LIMIT - w_cnt_cons;
        w_buf_next  = w_buf_cons;
        w_cnt_next  = w_cnt_cons[5:0];
        if (w_append) begin
            w_buf_next = (w_buf_cons & ~(c_BYTE_MASK << w_app_shift))
                       | ({{(BUF_W-8){1'b0}}, w_app_byte} << w_app_shift);
            w_cnt_next = w_cnt_cons[5:0] + 6'd8;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_DATA;
            r_buf           <= c_ALL_ONES;
            r_bit_count     <= 6'd0;
            r_marker_valid  <= 1'b0;
            r_marker_code   <= 8'h00;
            r_underflow_err <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_buf       <= w_buf_next;
            r_bit_count <= w_cnt_next;
            if (w_marker_hit) begin
                r_marker_valid <= 1'b1;
                r_marker_code  <= bus.in_data;
            end else if (w_flush) begin
                r_marker_valid <= 1'b0;
            end
            if (w_underflow) r_underflow_err <= 1'b1;
        end
    end

    assign bus.in_ready      = w_in_ready;
    assign bus.peek_bits     = r_buf[BUF_W-1 -: 16];
    assign bus.bit_count     = r_bit_count;
    assign bus.marker_valid  = r_marker_valid;
    assign bus.marker_code   = r_marker_code;
    assign bus.underflow_err = r_underflow_err;

endmodule
`default_nettype wire

// File: tb/tb_jpeg_entropy_unstuffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_jpeg_entropy_unstuffer
// Description : Directed self-checking bench for jpeg_entropy_unstuffer
//               (BUF_W = 32) with hand-computed expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jpeg_entropy_unstuffer;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    jpeg_entropy_unstuffer_if bus ();

    jpeg_entropy_unstuffer #(.BUF_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, sample 1 ns after the edge, return to idle.
    task automatic step(input logic v, input logic [7:0] d, input logic ce,
                        input logic [4:0] cl, input logic ack);
        bus.in_valid    = v;
        bus.in_data     = d;
        bus.consume_en  = ce;
        bus.consume_len = cl;
        bus.marker_ack  = ack;
        @(posedge clk); #1;
        bus.in_valid    = 1'b0;
        bus.consume_en  = 1'b0;
        bus.consume_len = 5'd0;
        bus.marker_ack  = 1'b0;
    endtask

    task automatic send(input logic [7:0] d);
        step(1'b1, d, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic consume(input logic [4:0] n);
        step(1'b0, 8'h00, 1'b1, n, 1'b0);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.consume_en = 1'b0;
        bus.consume_len = 5'd0; bus.marker_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); else n_pass++;
        n_total++;
        if (bus.bit_count !== 6'd0) $display("FAIL reset_count: got %0d want 0", bus.bit_count); else n_pass++;
        n_total++;
        if (bus.peek_bits !== 16'hFFFF) $display("FAIL reset_peek: got %h want ffff", bus.peek_bits); else n_pass++;
        n_total++;
        if (bus.marker_valid !== 1'b0) $display("FAIL reset_marker_valid: got %b want 0", bus.marker_valid); else n_pass++;
        n_total++;
        if (bus.marker_code !== 8'h00) $display("FAIL reset_marker_code: got %h want 00", bus.marker_code); else n_pass++;
        n_total++;
        if (bus.underflow_err !== 1'b0) $display("FAIL reset_underflow: got %b want 0", bus.underflow_err); else n_pass++;
        n_total++;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        send(8'hA5);
        if (bus.bit_count !== 6'd8) $display("FAIL basic_latency: got %0d want 8", bus.bit_count); else n_pass++;
        n_total++;
        send(8'h3C);
        if (bus.bit_count !== 6'd16) $display("FAIL basic_count: got %0d want 16", bus.bit_count); else n_pass++;
        n_total++;
        if (bus.peek_bits !== 16'hA53C) $display("FAIL basic_peek: got %h want a53c", bus.peek_bits); else n_pass++;
        n_total++;
        consume(5'd4);
        if (bus.peek_bits !== 16'h53CF) $display("FAIL basic_consume_peek: got %h want 53cf", bus.peek_bits); else n_pass++;
        n_total++;
        if (bus.bit_count !== 6'd12) $display("FAIL basic_consume_count: got %0d want 12", bus.bit_count); else n_pass++;
        n_total++;
        consume(5'd12);
        if (bus.peek_bits !== 16'hFFFF) $display("FAIL basic_drain_peek: got %h want ffff", bus.peek_bits); else n_pass++;
        n_total++;
    endtask

    task automatic test_stuffing;
        send(8'h12); send(8'hFF);
        if (bus.bit_count !== 6'd8) $display("FAIL stuff_ff_pending: got %0d want 8", bus.bit_count); else n_pass++;
        n_total++;
        send(8'h00); send(8'h34);
        if (bus.bit_count !== 6'd24) $display("FAIL stuff_count: got %0d want 24", bus.bit_count); else n_pass++;
        n_total++;
        if (bus.peek_bits !== 16'h12FF) $display("FAIL stuff_peek: got %h want 12ff", bus.peek_bits); else n_pass++;
        n_total++;
        consume(5'd8);
        if (bus.peek_bits !== 16'hFF34) $display("FAIL stuff_consume_peek: got %h want ff34", bus.peek_bits); else n_pass++;
        n_total++;
        consume(5'd16);
        if (bus.bit_count !== 6'd0) $display("FAIL stuff_drain: got %0d want 0", bus.bit_count); else n_pass++;
        n_total++;
    endtask

    task automatic test_marker;
        send(8'hAB); send(8'hFF); send(8'hFF);
        if (bus.marker_valid !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL marker_fill: got valid=%b ready=%b want 0/1", bus.marker_valid, bus.in_ready);
        else n_pass++;
        n_total++;
        send(8'hD3);
        if (bus.marker_valid !== 1'b1) $display("FAIL marker_valid: got %b want 1", bus.marker_valid); else n_pass++;
        n_total++;
        if (bus.marker_code !== 8'hD3) $display("FAIL marker_code: got %h want d3", bus.marker_code); else n_pass++;
        n_total++;
        if (bus.in_ready !== 1'b0) $display("FAIL marker_in_ready: got %b want 0", bus.in_ready); else n_pass++;
        n_total++;
        if (bus.bit_count !== 6'd8) $display("FAIL marker_count: got %0d want 8", bus.bit_count); else n_pass++;
        n_total++;
        send(8'h55);
        if (bus.peek_bits !== 16'hABFF) $display("FAIL marker_halt_peek: got %h want abff", bus.peek_bits); else n_pass++;
        n_total++;
        consume(5'd8);
        if (bus.bit_count !== 6'd0 || bus.marker_valid !== 1'b1)
            $display("FAIL marker_drain: got count=%0d valid=%b want 0/1", bus.bit_count, bus.marker_valid);
        else n_pass++;
        n_total++;
        step(1'b0, 8'h00, 1'b0, 5'd0, 1'b1);
        if (bus.marker_valid !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL marker_ack: got valid=%b ready=%b want 0/1", bus.marker_valid, bus.in_ready);
        else n_pass++;
        n_total++;
        if (bus.marker_code !== 8'hD3) $display("FAIL marker_code_hold: got %h want d3", bus.marker_code); else n_pass++;
        n_total++;
        send(8'h11); send(8'hFF); send(8'hD9);
        if (bus.marker_code !== 8'hD9 || bus.bit_count !== 6'd8)
            $display("FAIL marker_eoi: got code=%h count=%0d want d9/8", bus.marker_code, bus.bit_count);
        else n_pass++;
        n_total++;
        step(1'b0, 8'h00, 1'b1, 5'd4, 1'b1);
        if (bus.bit_count !== 6'd0 || bus.peek_bits !== 16'hFFFF || bus.marker_valid !== 1'b0)
            $display("FAIL marker_ack_consume: got count=%0d peek=%h valid=%b want 0/ffff/0",
                     bus.bit_count, bus.peek_bits, bus.marker_valid);
        else n_pass++;
        n_total++;
    endtask

    task automatic test_back_to_back;
        send(8'h01); send(8'h23); send(8'h45);
        if (bus.in_ready !== 1'b1) $display("FAIL full_ready_at_24: got %b want 1", bus.in_ready); else n_pass++;
        n_total++;
        send(8'h67);
        if (bus.in_ready !== 1'b0 || bus.bit_count !== 6'd32)
            $display("FAIL full_ready_at_32: got ready=%b count=%0d want 0/32", bus.in_ready, bus.bit_count);
        else n_pass++;
        n_total++;
        if (bus.peek_bits !== 16'h0123) $display("FAIL full_peek: got %h want 0123", bus.peek_bits); else n_pass++;
        n_total++;
        step(1'b1, 8'h89, 1'b1, 5'd16, 1'b0);
        if (bus.bit_count !== 6'd16 || bus.in_ready !== 1'b1)
            $display("FAIL full_consume_offer: got count=%0d ready=%b want 16/1", bus.bit_count, bus.in_ready);
        else n_pass++;
        n_total++;
        if (bus.peek_bits !== 16'h4567) $display("FAIL full_byte_rejected: got %h want 4567", bus.peek_bits); else n_pass++;
        n_total++;
        step(1'b1, 8'h9A, 1'b1, 5'd8, 1'b0);
        if (bus.peek_bits !== 16'h679A || bus.bit_count !== 6'd16)
            $display("FAIL simul_consume_append: got peek=%h count=%0d want 679a/16", bus.peek_bits, bus.bit_count);
        else n_pass++;
        n_total++;
        consume(5'd16);
    endtask

    task automatic test_underflow;
        send(8'hF0);
        consume(5'd3);
        if (bus.peek_bits !== 16'h87FF || bus.bit_count !== 6'd5)
            $display("FAIL uf_setup: got peek=%h count=%0d want 87ff/5", bus.peek_bits, bus.bit_count);
        else n_pass++;
        n_total++;
        step(1'b1, 8'hC3, 1'b1, 5'd9, 1'b0);
        if (bus.underflow_err !== 1'b1) $display("FAIL uf_flag: got %b want 1", bus.underflow_err); else n_pass++;
        n_total++;
        if (bus.bit_count !== 6'd8 || bus.peek_bits !== 16'hC3FF)
            $display("FAIL uf_append: got count=%0d peek=%h want 8/c3ff", bus.bit_count, bus.peek_bits);
        else n_pass++;
        n_total++;
        consume(5'd0);
        if (bus.bit_count !== 6'd8) $display("FAIL zero_len_noop: got %0d want 8", bus.bit_count); else n_pass++;
        n_total++;
        step(1'b1, 8'h5A, 1'b0, 5'd0, 1'b1);
        if (bus.bit_count !== 6'd16 || bus.peek_bits !== 16'hC35A)
            $display("FAIL stray_ack: got count=%0d peek=%h want 16/c35a", bus.bit_count, bus.peek_bits);
        else n_pass++;
        n_total++;
        if (bus.underflow_err !== 1'b1) $display("FAIL uf_sticky: got %b want 1", bus.underflow_err); else n_pass++;
        n_total++;
        send(8'hFF);
    endtask

    task automatic test_async_reset;
        #2 rst_n = 1'b0;
        #1;
        if (bus.bit_count !== 6'd0 || bus.peek_bits !== 16'hFFFF || bus.in_ready !== 1'b1)
            $display("FAIL areset_buffer: got count=%0d peek=%h ready=%b want 0/ffff/1",
                     bus.bit_count, bus.peek_bits, bus.in_ready);
        else n_pass++;
        n_total++;
        if (bus.underflow_err !== 1'b0 || bus.marker_valid !== 1'b0 || bus.marker_code !== 8'h00)
            $display("FAIL areset_flags: got uf=%b valid=%b code=%h want 0/0/00",
                     bus.underflow_err, bus.marker_valid, bus.marker_code);
        else n_pass++;
        n_total++;
        rst_n = 1'b1;
        @(posedge clk); #1;
        // A pending 0xFF before reset must be forgotten: 0x00 is plain data.
        send(8'h00);
        if (bus.peek_bits !== 16'h00FF || bus.bit_count !== 6'd8)
            $display("FAIL areset_state: got peek=%h count=%0d want 00ff/8", bus.peek_bits, bus.bit_count);
        else n_pass++;
        n_total++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_basic();
        test_stuffing();
        test_marker();
        test_back_to_back();
        test_underflow();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
